// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Converts the read side of a standard (one-cycle read latency) FIFO into a
// valid/ready stream. A 2-entry in-order buffer (head, tail) absorbs the read
// latency so that, with the consumer always ready, one word is delivered per
// clock with no bubbles once the pipe has filled.
//
// Ports
//   clk          : single clock, all state changes on the rising edge
//   rst          : asynchronous, active-high reset
//   fifo_empty   : upstream FIFO empty flag
//   fifo_rd_en   : read request to the upstream FIFO
//   fifo_rd_data : upstream read data, valid the cycle after an accepted read
//   m_valid      : stream word on m_data is valid
//   m_ready      : downstream consumer accepts the word
//   m_data       : stream data, driven from the head buffer register
//   occupancy    : words currently held in the buffer (0..2); this is the
//                  state register of the buffer FSM, exposed for checkers
//   xfer_count   : count of delivered beats, wraps from 16'hFFFF to 0
//
// Handshake: a beat transfers on a rising edge where m_valid && m_ready.
// Once m_valid is high it stays high, with m_data unchanged, until that beat
// transfers; m_valid never depends on m_ready.
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            occupancy,
    output logic [15:0]           xfer_count
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    occ_e                  occ_q, occ_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [15:0]           xfer_q, xfer_d;

    logic                  pop;
    logic                  push;
    logic [2:0]            level_after;

    assign m_valid    = (occ_q != OCC_EMPTY);
    assign m_data     = head_q;
    assign occupancy  = occ_q;
    assign xfer_count = xfer_q;

    assign pop  = m_valid && m_ready;
    // A read issued last cycle returns its word this cycle.
    assign push = inflight_q;

    // Words that will be held or still owed after this edge. Only issue a new
    // read if that count leaves room for it; this guarantees a returning word
    // never finds the buffer full. pop implies occ_q >= 1, so no underflow.
    assign level_after = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en  = !rst && !fifo_empty && (level_after < 3'd2);

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        xfer_d = xfer_q;

        case ({push, pop})
            2'b10: begin
                case (occ_q)
                    OCC_EMPTY: begin
                        head_d = fifo_rd_data;
                        occ_d  = OCC_ONE;
                    end
                    OCC_ONE: begin
                        tail_d = fifo_rd_data;
                        occ_d  = OCC_TWO;
                    end
                    default: occ_d = occ_q;
                endcase
            end
            2'b01: begin
                if (occ_q == OCC_TWO) begin
                    head_d = tail_q;
                    occ_d  = OCC_ONE;
                end else begin
                    occ_d = OCC_EMPTY;
                end
            end
            2'b11: begin
                // Head leaves and a new word arrives in the same edge: the
                // newcomer lands behind whatever remains.
                if (occ_q == OCC_TWO) begin
                    head_d = tail_q;
                    tail_d = fifo_rd_data;
                end else begin
                    head_d = fifo_rd_data;
                end
            end
            default: occ_d = occ_q;
        endcase

        if (pop) begin
            xfer_d = xfer_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q      <= OCC_EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            xfer_q     <= 16'd0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
            xfer_q     <= xfer_d;
        end
    end

endmodule
